// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN front-end blocks.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_line_buffer.sv
// One image row of storage: combinational read of the old entry, write on the clock edge.
module sw_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_WIDTH,
    parameter int ADDR_W     = clog2(DEF_IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Read sees the previous contents, so the cascade shifts a column up per accept.
    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sliding_window_kxk.sv
// KxK sliding window generator over a raster pixel stream with stride and ready/valid flow control.
module sliding_window_kxk
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [K*K*DATA_WIDTH-1:0] window
);

    localparam int CW = clog2(IMG_WIDTH);
    localparam int RW = clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] C_MAX  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] C_KM1  = CW'(K - 1);
    localparam logic [CW-1:0] C_SM1  = CW'(STRIDE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(K - 1 + ((IMG_WIDTH - K) / STRIDE) * STRIDE);
    localparam logic [RW-1:0] R_MAX  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] R_KM1  = RW'(K - 1);
    localparam logic [RW-1:0] R_SM1  = RW'(STRIDE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(K - 1 + ((IMG_HEIGHT - K) / STRIDE) * STRIDE);

    logic [RW-1:0] r_q, r_d, rph_q, rph_d, cur_r, cur_rph;
    logic [CW-1:0] c_q, c_d, cph_q, cph_d, cur_c, cur_cph;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          accept, emit, is_last;

    logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_q, win_d, out_win_q, out_win_d;
    logic [K-2:0][DATA_WIDTH-1:0]        lb_rd, lb_wr;
    logic [K-1:0][DATA_WIDTH-1:0]        col;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Buffer K-2 holds the previous row; each lower buffer receives the row evicted above it.
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        if (g == K - 2) begin : g_top
            assign lb_wr[g] = pixel_in;
        end else begin : g_mid
            assign lb_wr[g] = lb_rd[g+1];
        end
        sw_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (IMG_WIDTH),
            .ADDR_W    (CW)
        ) u_lb (
            .clk    (clk),
            .we     (accept),
            .addr   (cur_c),
            .wr_data(lb_wr[g]),
            .rd_data(lb_rd[g])
        );
    end

    always_comb begin
        cur_r   = in_sof ? '0 : r_q;
        cur_c   = in_sof ? '0 : c_q;
        cur_rph = in_sof ? '0 : rph_q;
        cur_cph = in_sof ? '0 : cph_q;

        for (int i = 0; i < K - 1; i++) begin
            col[i] = lb_rd[i];
        end
        col[K-1] = pixel_in;

        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = col[i];
            end
        end

        r_d   = r_q;
        c_d   = c_q;
        rph_d = rph_q;
        cph_d = cph_q;
        if (accept) begin
            r_d   = cur_r;
            rph_d = cur_rph;
            if (cur_c == C_MAX) begin
                c_d = '0;
                r_d = (cur_r == R_MAX) ? '0 : cur_r + 1'b1;
                // Phase stays 0 until the first full window row, then counts modulo STRIDE.
                if (r_d <= R_KM1) rph_d = '0;
                else              rph_d = (cur_rph == R_SM1) ? '0 : cur_rph + 1'b1;
            end else begin
                c_d = cur_c + 1'b1;
            end
            if (c_d <= C_KM1) cph_d = '0;
            else              cph_d = (cur_cph == C_SM1) ? '0 : cur_cph + 1'b1;
        end

        emit    = accept && (cur_r >= R_KM1) && (cur_c >= C_KM1) &&
                  (cur_rph == '0) && (cur_cph == '0);
        is_last = (cur_r == R_LAST) && (cur_c == C_LAST);

        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q && !out_ready;
        out_win_d   = out_win_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = is_last;
            out_win_d   = win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            c_q         <= '0;
            rph_q       <= '0;
            cph_q       <= '0;
            win_q       <= '0;
            out_win_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            rph_q       <= rph_d;
            cph_q       <= cph_d;
            win_q       <= win_d;
            out_win_q   <= out_win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign window    = out_win_q;

endmodule

// File: doc/sliding_window_kxk.md
SLIDING_WINDOW_KXK -- requirements
Module: sliding_window_kxk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 28: pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 28: rows per frame.
REQ-004 SHALL have parameter K, default 3: window edge; legal 2..min(IMG_WIDTH,IMG_HEIGHT).
REQ-005 SHALL have parameter STRIDE, default 1: window step in rows and columns; legal 1..K.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1: pixel_in is valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a pixel this cycle.
REQ-010 SHALL have port in_sof, input, 1: qualifies the first pixel of a frame.
REQ-011 SHALL have port pixel_in, input, DATA_WIDTH: raster-order pixel.
REQ-012 SHALL have port out_valid, output, 1: window valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the window.
REQ-014 SHALL have port out_last, output, 1: last window of the frame.
REQ-015 SHALL have port window, output, K*K*DATA_WIDTH: element (i,j) at bits [(i*K+j)*DATA_WIDTH +: DATA_WIDTH]; i is the row (0 = oldest), j is the column (0 = leftmost).

Function
REQ-016 SHALL accept a pixel only on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL track the accepted pixel position (r,c): c increments per accept; at c=IMG_WIDTH-1, c wraps to 0 and r increments; at (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
REQ-019 SHALL treat an accepted pixel with in_sof=1 as position (0,0) regardless of the counter state, restarting the stride phase counters. Line buffer contents are kept.
REQ-020 SHALL hold K-1 line buffers of IMG_WIDTH entries and a KxK register window, all updated only on accept.
REQ-021 On each accept, the window SHALL shift one column left, and the new right column SHALL be the buffered column c (oldest row first) followed by pixel_in.
REQ-022 SHALL emit a window when the accepted pixel satisfies all of:
  - r>=K-1;
  - c>=K-1;
  - (r-K+1) mod STRIDE = 0;
  - (c-K+1) mod STRIDE = 0.
  The stride tests SHALL use phase counters, not division.
REQ-023 An emitted window element (i,j) SHALL equal pixel(r-K+1+i, c-K+1+j).
REQ-024 SHALL assert out_valid, window and out_last one cycle after the qualifying accept (latency 1).
REQ-025 SHALL hold out_valid, window and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear out_valid after a handshake unless a new window is emitted on the same cycle (back-to-back allowed).
REQ-027 SHALL assert out_last only on the window whose bottom-right pixel is the last qualifying position of the frame.
REQ-028 SHALL never emit windows that straddle row or frame borders; no padding.
REQ-029 SHALL emit ((IMG_HEIGHT-K)/STRIDE+1)*((IMG_WIDTH-K)/STRIDE+1) windows per full frame (integer division).

Reset
REQ-030 While rst=1 the block SHALL drive out_valid=0, out_last=0 and window=0, and clear the row, column and phase counters to 0.
REQ-031 Reset SHALL NOT require line buffer clearing; stale contents SHALL never reach an emitted window.
REQ-032 Reset asserted mid-frame SHALL discard the pending window; the next accepted pixel is (0,0).

Structure
REQ-033 A shared package cnn_pkg SHALL hold the clog2 helper and the default DATA_WIDTH, IMG_WIDTH and IMG_HEIGHT constants.
REQ-034 The line buffer SHALL be a sub-module sw_line_buffer:
  - one IMG_WIDTH x DATA_WIDTH row;
  - write enable, address, read-before-write;
  - instantiated K-1 times in a cascade.
REQ-035 Counter widths SHALL be clog2(IMG_WIDTH) and clog2(IMG_HEIGHT).

Verification
REQ-036 W=H=5, K=3, S=1, pixels 0..24, out_ready=1 -> 9 windows:
  - first {0,1,2,5,6,7,10,11,12}, 1 cycle after pixel 12 is accepted;
  - last {12,13,14,17,18,19,22,23,24} with out_last=1.
REQ-037 W=H=5, K=3, S=2 -> 4 windows with bottom-right pixels 12, 14, 22, 24; out_last only on 24.
REQ-038 Hold out_ready=0 for 5 cycles while a window is pending -> in_ready=0, window unchanged, no pixel lost; the sequence continues correctly after release.
REQ-039 Assert in_sof on the 8th pixel of a frame, then send 25 pixels -> windows match a frame starting at that pixel, 9 windows.
REQ-040 Assert rst after pixel 13, then send a full frame -> no output during reset; the following frame yields exactly the 9 correct windows.
REQ-041 Send two frames back-to-back, in_valid=1 continuous -> 18 windows, out_last twice, no bubble between frames.
